// File: rtl/desloc_pkg.sv
// desloc_pkg -- shared definitions for the shift sequencer and its datapath.
//
// Holds the shift-register mode encodings (also used as the sr_select
// values) and the sequencer FSM state encoding, so that desloc_seq and the
// reg_desloc benches agree on both.

package desloc_pkg;

  // Shift-register mode select. OP_LOAD doubles as "load/hold": the
  // register takes sr_data unchanged.
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ASR  = 2'b11
  } desloc_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_CAPT  = 2'b11
  } desloc_state_e;

endpackage

// File: rtl/desloc_seq.sv
// desloc_seq -- command sequencer for an external shift register (reg_desloc).
//
// A start strobe in IDLE latches op/amount/din.
// - LOAD pushes din into the shift register.
// - SHIFT applies the latched mode for `amount` cycles, feeding the
//   register's own output back in as data.
// - CAPT registers the final value into result.
// - done pulses for one cycle in the IDLE cycle that follows.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   start      command strobe, only honoured while busy=0
//   din        operand
//   op         shift mode (see desloc_op_e)
//   amount     number of shift steps
//   busy       high while a command is in progress
//   done       one-cycle completion pulse (registered)
//   result     final value, held until the next capture
//   sr_enable  shift-register enable
//   sr_select  shift-register mode select
//   sr_data    shift-register data input
//   sr_out     shift-register output (feedback from reg_desloc)

module desloc_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sr_enable,
  output logic [1:0]       sr_select,
  output logic [WIDTH-1:0] sr_data,
  input  logic [WIDTH-1:0] sr_out
);

  import desloc_pkg::*;

  desloc_state_e state_q, state_d;

  desloc_op_e        op_q;
  logic [AMT_W-1:0]  amt_q;
  logic [AMT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  din_q;

  assign busy = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore decode of the shift-register controls.
  // IDLE and CAPT leave the register untouched with select/data parked at 0.
  always_comb begin
    state_d   = state_q;
    sr_enable = 1'b0;
    sr_select = OP_LOAD;
    sr_data   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_enable = 1'b1;
        sr_select = OP_LOAD;
        sr_data   = din_q;
        state_d   = (amt_q != '0) ? ST_SHIFT : ST_CAPT;
      end
      ST_SHIFT: begin
        sr_enable = 1'b1;
        sr_select = op_q;
        sr_data   = sr_out;
        // cnt_q counts the remaining steps including this one; the <= also
        // steers an (unreachable) zero count out of SHIFT instead of stalling.
        if (cnt_q <= AMT_W'(1)) begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command latches, step counter, result capture and the done pulse.
  // done is simply "the previous cycle was CAPT", which places it in the
  // first IDLE cycle, where a new start is already accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q   <= OP_LOAD;
      amt_q  <= '0;
      cnt_q  <= '0;
      din_q  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state_q == ST_CAPT);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q  <= desloc_op_e'(op);
            amt_q <= amount;
            cnt_q <= amount;
            din_q <= din;
          end
        end
        ST_SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - AMT_W'(1);
          end
        end
        ST_CAPT: begin
          result <= sr_out;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
